result_writeback: RTL and testbench

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback_if.sv | 53 +++++
 rtl/result_writeback.sv | 242 ++++++++++++++++++++++++
 tb/tb_result_writeback.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_writeback_if.sv
// ---------------------------------------------------------------------------
// result_writeback_if
//
// Bundles every non-clock/reset signal of result_writeback.
//   Control : WB_START, DIMEN[1:0], ADDRESS[3:0], WB_BUSY, WB_DONE
//   PE side : PE_VALID, PE_ACK, PE_DOUT_0..PE_DOUT_3 (32 bits each)
//   BRAM    : addrb[31:0], dinb[31:0], enb, web[3:0]
//   Option  : WB_CSUM[31:0], present only when WB_CHECKSUM_EN is defined
//
// Modports:
//   master - the environment (sequencer, PE array and BRAM observer)
//   slave  - the result_writeback block itself
// ---------------------------------------------------------------------------
interface result_writeback_if;

    logic        WB_START;
    logic [1:0]  DIMEN;
    logic [3:0]  ADDRESS;
    logic        PE_VALID;
    logic        PE_ACK;
    logic [31:0] PE_DOUT_0;
    logic [31:0] PE_DOUT_1;
    logic [31:0] PE_DOUT_2;
    logic [31:0] PE_DOUT_3;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic        enb;
    logic [3:0]  web;
    logic        WB_BUSY;
    logic        WB_DONE;
`ifdef WB_CHECKSUM_EN
    logic [31:0] WB_CSUM;
`endif

    modport master (
`ifdef WB_CHECKSUM_EN
        input  WB_CSUM,
`endif
        output WB_START, DIMEN, ADDRESS, PE_VALID,
        output PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3,
        input  PE_ACK, addrb, dinb, enb, web, WB_BUSY, WB_DONE
    );

    modport slave (
`ifdef WB_CHECKSUM_EN
        output WB_CSUM,
`endif
        input  WB_START, DIMEN, ADDRESS, PE_VALID,
        input  PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3,
        output PE_ACK, addrb, dinb, enb, web, WB_BUSY, WB_DONE
    );

endinterface

// File: rtl/result_writeback.sv
// ---------------------------------------------------------------------------
// result_writeback
//
// Drains processing-element results into a BRAM port B. A transfer of
// 2/4/8/16 words (DIMEN = 0/1/2/3) starts with a WB_START pulse in IDLE.
// Results arrive as groups of four lanes (PE_DOUT_0..3, qualified by
// PE_VALID and consumed with PE_ACK); each group is latched and then written
// one word per cycle to consecutive BRAM word addresses starting at ADDRESS.
// A 2-word transfer uses only lanes 0 and 1 of its single group.
//
// Ports:
//   CLK   - clock, rising edge active
//   RSTN  - asynchronous active-low reset
//   bus   - result_writeback_if.slave
//             WB_START, DIMEN, ADDRESS           : transfer request
//             PE_VALID, PE_ACK, PE_DOUT_0..3     : PE result handshake
//             addrb, dinb, enb, web              : BRAM write port
//             WB_BUSY, WB_DONE                   : status
//             WB_CSUM                            : XOR of written words
//
// Build option:
//   WB_CHECKSUM_EN - when defined, adds the WB_CSUM running XOR checksum
//                    (cleared at start, updated on every write, held after).
//
// Outputs other than PE_ACK are decoded purely from registered state, so
// they carry no combinational path from any input. PE_ACK mirrors PE_VALID
// while waiting for a group so the producer sees consumption in-cycle.
// ---------------------------------------------------------------------------
module result_writeback (
    input  logic                 CLK,
    input  logic                 RSTN,
    result_writeback_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } wb_state_t;

    // Running checksum update; XOR keeps the signature order-independent.
    function automatic logic [31:0] csum_fold(input logic [31:0] acc,
                                              input logic [31:0] word);
        csum_fold = acc ^ word;
    endfunction

    // Transfer length in words for a DIMEN code: 2 << dimen.
    function automatic logic [4:0] total_words(input logic [1:0] dimen);
        total_words = 5'd2 << dimen;
    endfunction

    wb_state_t   state_r;
    wb_state_t   state_nxt_s;

    logic [1:0]  dimen_r;
    logic [3:0]  addr_r;
    logic [4:0]  wcnt_r;
    logic [31:0] lane_r [4];

    logic [4:0]  total_s;
    logic [4:0]  wcnt_inc_s;
    logic [4:0]  addr_sum_s;
    logic        last_in_grp_s;
    logic        more_words_s;

    logic        pe_ack_s;
    logic        enb_s;
    logic [3:0]  web_s;
    logic [31:0] dinb_s;
    logic [31:0] addrb_s;

    // Transfer bookkeeping derived from the latched request and word count.
    always_comb begin
        total_s    = total_words(dimen_r);
        wcnt_inc_s = wcnt_r + 5'd1;
        // Five-bit sum so a base near the top of the 4-bit range carries
        // into bit 4 instead of wrapping back to low addresses.
        addr_sum_s = {1'b0, addr_r} + {1'b0, wcnt_r[3:0]};
        // A group ends on lane 3, or earlier when the transfer itself ends
        // (the 2-word case stops after lane 1).
        if ((wcnt_r[1:0] == 2'd3) || (wcnt_inc_s == total_s)) begin
            last_in_grp_s = 1'b1;
        end else begin
            last_in_grp_s = 1'b0;
        end
        if (total_s > wcnt_inc_s) begin
            more_words_s = 1'b1;
        end else begin
            more_words_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.WB_START) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                if (bus.PE_VALID) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            WRITE: begin
                if (last_in_grp_s) begin
                    if (more_words_s) begin
                        state_nxt_s = CAPTURE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                // WB_START here is deliberately not looked at.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: BRAM port is quiet (all zero) outside WRITE.
    always_comb begin
        pe_ack_s = 1'b0;
        enb_s    = 1'b0;
        web_s    = 4'b0000;
        dinb_s   = 32'd0;
        addrb_s  = 32'd0;
        case (state_r)
            CAPTURE: begin
                pe_ack_s = bus.PE_VALID;
            end
            WRITE: begin
                enb_s   = 1'b1;
                web_s   = 4'b1111;
                dinb_s  = lane_r[wcnt_r[1:0]];
                addrb_s = {27'd0, addr_sum_s};
            end
            default: begin
                pe_ack_s = 1'b0;
            end
        endcase
    end

    // Request latch, word counter and lane registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dimen_r <= 2'd0;
            addr_r  <= 4'd0;
            wcnt_r  <= 5'd0;
            for (int i = 0; i < 4; i++) begin
                lane_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.WB_START) begin
                        dimen_r <= bus.DIMEN;
                        addr_r  <= bus.ADDRESS;
                        wcnt_r  <= 5'd0;
                    end else begin
                        wcnt_r  <= wcnt_r;
                    end
                end
                CAPTURE: begin
                    if (bus.PE_VALID) begin
                        lane_r[0] <= bus.PE_DOUT_0;
                        lane_r[1] <= bus.PE_DOUT_1;
                        lane_r[2] <= bus.PE_DOUT_2;
                        lane_r[3] <= bus.PE_DOUT_3;
                    end else begin
                        wcnt_r <= wcnt_r;
                    end
                end
                WRITE: begin
                    wcnt_r <= wcnt_inc_s;
                end
                default: begin
                    wcnt_r <= wcnt_r;
                end
            endcase
        end
    end

`ifdef WB_CHECKSUM_EN
    logic [31:0] csum_r;

    // Checksum of every word written in the current transfer.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            csum_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.WB_START) begin
                        csum_r <= 32'd0;
                    end else begin
                        csum_r <= csum_r;
                    end
                end
                WRITE: begin
                    csum_r <= csum_fold(csum_r, dinb_s);
                end
                default: begin
                    csum_r <= csum_r;
                end
            endcase
        end
    end

    assign bus.WB_CSUM = csum_r;
`endif

    assign bus.PE_ACK  = pe_ack_s;
    assign bus.enb     = enb_s;
    assign bus.web     = web_s;
    assign bus.dinb    = dinb_s;
    assign bus.addrb   = addrb_s;
    assign bus.WB_BUSY = (state_r != IDLE);
    assign bus.WB_DONE = (state_r == DONE);

endmodule

// File: tb/tb_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_result_writeback
//
// Directed bench for result_writeback. Inputs change 1 time unit after the
// rising edge; a negedge monitor logs BRAM writes and handshake pulses.
// Expected values are written out by hand in each scenario.
// ---------------------------------------------------------------------------
module tb_result_writeback;

    logic CLK;
    logic RSTN;

    result_writeback_if bus ();

    result_writeback dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int ack_cnt;
    int done_cnt;
    int stall_enb_cnt;
    int idle_bus_cnt;
    int web_bad_cnt;
    bit stalling;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observe the DUT mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (bus.enb === 1'b1) begin
            wr_addr_q.push_back(bus.addrb);
            wr_data_q.push_back(bus.dinb);
            if (bus.web !== 4'hF) web_bad_cnt++;
            if (stalling) stall_enb_cnt++;
        end else if (bus.addrb !== 32'd0 || bus.dinb !== 32'd0 || bus.web !== 4'd0) begin
            idle_bus_cnt++;
        end
        if (bus.PE_ACK === 1'b1) ack_cnt++;
        if (bus.WB_DONE === 1'b1) done_cnt++;
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ack_cnt       = 0;
        done_cnt      = 0;
        stall_enb_cnt = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_xfer(input logic [1:0] dim, input logic [3:0] addr);
        bus.DIMEN    = dim;
        bus.ADDRESS  = addr;
        bus.WB_START = 1'b1;
        tick();
        bus.WB_START = 1'b0;
        // Scramble the request inputs; the latched copy must be used.
        bus.DIMEN    = ~dim;
        bus.ADDRESS  = ~addr;
    endtask

    // Wait until the block is waiting for a group (busy, not writing).
    task automatic wait_capture(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.WB_BUSY && !bus.enb && !bus.WB_DONE) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check({tag, "_capture_timeout"}, 32'd0, 32'd1);
    endtask

    // Stall `delay` cycles, then offer one group; returns just after the
    // consuming edge (first write of the group is on the bus).
    task automatic present_group(input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input int delay);
        wait_capture("grp");
        stalling = 1'b1;
        repeat (delay) tick();
        stalling = 1'b0;
        bus.PE_DOUT_0 = d0;
        bus.PE_DOUT_1 = d1;
        bus.PE_DOUT_2 = d2;
        bus.PE_DOUT_3 = d3;
        bus.PE_VALID  = 1'b1;
        #1;
        check("pe_ack_in_capture", bus.PE_ACK, 1'b1);
        @(posedge CLK);
        #1;
        bus.PE_VALID = 1'b0;
    endtask

    // Count edges until WB_DONE is seen; bounded.
    task automatic wait_done(input string tag, output int cycles);
        bit ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            if (bus.WB_DONE) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        RSTN          = 1'b0;
        bus.WB_START  = 1'b0;
        bus.DIMEN     = 2'd0;
        bus.ADDRESS   = 4'd0;
        bus.PE_VALID  = 1'b1;
        bus.PE_DOUT_0 = 32'd0;
        bus.PE_DOUT_1 = 32'd0;
        bus.PE_DOUT_2 = 32'd0;
        bus.PE_DOUT_3 = 32'd0;
        stalling      = 1'b0;
        idle_bus_cnt  = 0;
        web_bad_cnt   = 0;
        clear_log();

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_enb",    bus.enb,     1'b0);
        check("rst_web",    bus.web,     4'h0);
        check("rst_addrb",  bus.addrb,   32'd0);
        check("rst_dinb",   bus.dinb,    32'd0);
        check("rst_busy",   bus.WB_BUSY, 1'b0);
        check("rst_done",   bus.WB_DONE, 1'b0);
        check("rst_pe_ack", bus.PE_ACK,  1'b0);
`ifdef WB_CHECKSUM_EN
        check("rst_csum",   bus.WB_CSUM, 32'd0);
`endif
        RSTN = 1'b1;
        tick();
        // PE_VALID in IDLE is ignored.
        check("idle_pe_ack", bus.PE_ACK,  1'b0);
        check("idle_busy",   bus.WB_BUSY, 1'b0);
        bus.PE_VALID = 1'b0;
        tick();

        // ---------------- 2-word transfer at 4 ----------------
        clear_log();
        start_xfer(2'd0, 4'd4);
        check("t1_busy_after_start", bus.WB_BUSY, 1'b1);
        check("t1_no_enb_capture",   bus.enb,     1'b0);
        present_group(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
        // First write appears in the cycle right after the consuming edge.
        check("t1_first_enb",   bus.enb,   1'b1);
        check("t1_first_addr",  bus.addrb, 32'd4);
        check("t1_first_data",  bus.dinb,  32'hA0);
        wait_done("t1", n);
        check("t1_done_lat", n, 2);
        tick();
        check("t1_done_one_cycle", bus.WB_DONE, 1'b0);
        check("t1_idle",           bus.WB_BUSY, 1'b0);
        check("t1_nwr",   wr_addr_q.size(), 2);
        check("t1_a0",    wr_addr_q[0], 32'd4);
        check("t1_d0",    wr_data_q[0], 32'hA0);
        check("t1_a1",    wr_addr_q[1], 32'd5);
        check("t1_d1",    wr_data_q[1], 32'hA1);
        check("t1_ndone", done_cnt, 1);

        // ---------------- 16 words, stalled groups ----------------
        clear_log();
        start_xfer(2'd3, 4'd0);
        for (int g = 0; g < 4; g++) begin
            present_group(32'hC000_0000 | (g << 4) | 0, 32'hC000_0000 | (g << 4) | 1,
                          32'hC000_0000 | (g << 4) | 2, 32'hC000_0000 | (g << 4) | 3, 3);
        end
        wait_done("t2", n);
        check("t2_done_lat_last_grp", n, 4);
        tick();
        check("t2_nwr", wr_addr_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr_q.size()) begin
                check("t2_addr", wr_addr_q[i], i);
                check("t2_data", wr_data_q[i], 32'hC000_0000 | ((i / 4) << 4) | (i % 4));
            end
        end
        check("t2_nack",      ack_cnt, 4);
        check("t2_stall_enb", stall_enb_cnt, 0);
        check("t2_ndone",     done_cnt, 1);

        // ---------------- base 15, no address wrap ----------------
        clear_log();
        start_xfer(2'd1, 4'd15);
        present_group(32'h11, 32'h22, 32'h33, 32'h44, 0);
        wait_done("t3", n);
        // One capture edge plus four write edges after the start edge.
        check("t3_done_lat", n + 1, 5);
        tick();
        check("t3_nwr", wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) begin
            check("t3_a0", wr_addr_q[0], 32'd15);
            check("t3_a1", wr_addr_q[1], 32'd16);
            check("t3_a2", wr_addr_q[2], 32'd17);
            check("t3_a3", wr_addr_q[3], 32'd18);
            check("t3_d3", wr_data_q[3], 32'h44);
        end

        // ---------------- reset during 3rd write of 8 ----------------
        clear_log();
        start_xfer(2'd2, 4'd1);
        present_group(32'h51, 32'h52, 32'h53, 32'h54, 0);
        tick();
        tick();
        check("t4_third_write_addr", bus.addrb, 32'd3);
        RSTN = 1'b0;
        #1;
        check("t4_rst_enb",   bus.enb,     1'b0);
        check("t4_rst_web",   bus.web,     4'h0);
        check("t4_rst_busy",  bus.WB_BUSY, 1'b0);
        check("t4_rst_done",  bus.WB_DONE, 1'b0);
        check("t4_rst_addrb", bus.addrb,   32'd0);
`ifdef WB_CHECKSUM_EN
        check("t4_rst_csum",  bus.WB_CSUM, 32'd0);
`endif
        tick();
        #2;
        RSTN = 1'b1;
        repeat (3) tick();
        check("t4_no_done", done_cnt, 0);
        check("t4_nwr",     wr_addr_q.size(), 2);
        clear_log();
        start_xfer(2'd0, 4'd2);
        present_group(32'h61, 32'h62, 32'h63, 32'h64, 0);
        wait_done("t4b", n);
        tick();
        check("t4b_nwr",   wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("t4b_a1", wr_addr_q[1], 32'd3);
            check("t4b_d1", wr_data_q[1], 32'h62);
        end
        check("t4b_ndone", done_cnt, 1);

        // ---------------- WB_START mid-transfer and in DONE ----------------
        clear_log();
        start_xfer(2'd1, 4'd8);
        present_group(32'h71, 32'h72, 32'h73, 32'h74, 0);
        bus.WB_START = 1'b1;
        bus.DIMEN    = 2'd3;
        bus.ADDRESS  = 4'd0;
        tick();
        bus.WB_START = 1'b0;
        wait_done("t5", n);
        check("t5_done_lat", n, 3);
        bus.WB_START = 1'b1;
        tick();
        bus.WB_START = 1'b0;
        check("t5_start_in_done_ignored", bus.WB_BUSY, 1'b0);
        repeat (4) tick();
        check("t5_still_idle", bus.WB_BUSY, 1'b0);
        check("t5_ndone", done_cnt, 1);
        check("t5_nwr",   wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) begin
            check("t5_a0", wr_addr_q[0], 32'd8);
            check("t5_a3", wr_addr_q[3], 32'd11);
            check("t5_d2", wr_data_q[2], 32'h73);
        end

`ifdef WB_CHECKSUM_EN
        // ---------------- checksum ----------------
        clear_log();
        start_xfer(2'd1, 4'd0);
        check("t6_csum_cleared", bus.WB_CSUM, 32'd0);
        present_group(32'h1, 32'h2, 32'h4, 32'h8, 0);
        wait_done("t6", n);
        check("t6_csum_done", bus.WB_CSUM, 32'hF);
        repeat (2) tick();
        check("t6_csum_held", bus.WB_CSUM, 32'hF);
`endif

        check("bus_quiet_outside_write", idle_bus_cnt, 0);
        check("web_full_on_write",       web_bad_cnt,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
